rto_core_sequencer: RTL and testbench
=====================================

Name: rto_core_sequencer

Overview:
Run-control sequencer for one RTO core instance (timestamped 128-bit output FIFO, 64-bit counter compare).
- Drives the core's auto_start and flush inputs from host commands: arm at a start time, stop, flush, clear error.
- Watches the core's status outputs (timestamp_error, overflow_error, empty, counter_matched).
- Halts playback on error and keeps sticky error state, saturating statistics and a first-error capture for host readback.
- Sits between the AXI register bank and the RTO core in the DAC controller.

Parameters:
FLUSH_CYCLES, 4, number of cycles flush is held high per flush sequence (>=1)
DRAIN_IDLE, 16, consecutive empty cycles in RUNNING that end a run when AUTO_STOP=1
HALT_ON_ERROR, 1, 1: any core error moves RUNNING to HALTED; 0: errors are only recorded
AUTO_STOP, 1, 1: drained FIFO ends a run; 0: run until stop_cmd
CNT_W, 32, width of the match counter
ERR_CNT_W, 16, width of each error counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
counter  in  64  global timestamp counter, the same value the core compares
start_cmd  in  1  one-cycle pulse: arm run
start_time  in  64  start timestamp, sampled with start_cmd
stop_cmd  in  1  one-cycle pulse: stop run
flush_cmd  in  1  one-cycle pulse: flush core FIFO
clear_error  in  1  one-cycle pulse: clear sticky flags and error counters
core_timestamp_error  in  1  core timestamp_error
core_overflow_error  in  1  core overflow_error
core_timestamp_error_data  in  128  core timestamp_error_data
core_overflow_error_data  in  128  core overflow_error_data
core_empty  in  1  core empty
core_counter_matched  in  1  core counter_matched
auto_start  out  1  to core auto_start
flush  out  1  to core flush
state  out  3  current FSM state code
busy  out  1  state != IDLE
sticky_ts_err  out  1  timestamp error seen since last clear
sticky_ovf_err  out  1  overflow error seen since last clear
first_err_type  out  2  {ovf, ts} of the first error since last clear
first_err_data  out  128  data word of the first error
ts_err_count  out  ERR_CNT_W  saturating count of timestamp-error cycles
ovf_err_count  out  ERR_CNT_W  saturating count of overflow-error cycles
match_count  out  CNT_W  saturating count of counter_matched cycles

Behaviour:
- Reset: state=IDLE(0). All outputs 0. Reset mid-run drops auto_start and flush on the next edge; no flush sequence is issued.
- State codes: IDLE=0, ARMED=1, RUNNING=2, FLUSHING=3, HALTED=4.
- Outputs are registered. auto_start=1 only in RUNNING. flush=1 only in FLUSHING. Both are Moore outputs, so they change on the cycle after the transition edge.
- Command priority when several are asserted in one cycle: flush_cmd > stop_cmd > start_cmd.
- Commands not listed for a state are ignored. clear_error is honoured in every state.
- IDLE:
  - start_cmd: latch start_time, clear match_count, go to ARMED.
  - flush_cmd: go to FLUSHING.
- ARMED:
  - counter >= latched start time (unsigned): go to RUNNING. A start time already in the past enters RUNNING on the next cycle.
  - stop_cmd: go to IDLE.
  - flush_cmd: go to FLUSHING.
- RUNNING:
  - stop_cmd: go to IDLE.
  - core error with HALT_ON_ERROR=1: go to HALTED.
  - AUTO_STOP=1 and core_empty high for DRAIN_IDLE consecutive cycles: go to IDLE. The drain counter clears on any non-empty cycle and on entry to RUNNING.
  - stop_cmd and an error in the same cycle: go to IDLE; the error is still recorded.
- FLUSHING:
  - Hold flush for exactly FLUSH_CYCLES cycles, then go to IDLE.
  - All commands except clear_error are ignored.
- HALTED:
  - clear_error: go to IDLE.
  - flush_cmd: go to FLUSHING; sticky flags are kept.
  - start_cmd is ignored until the error is cleared.
- Error recording is active in every state and is independent of the FSM:
  - Each cycle an error input is high sets its sticky flag and increments its counter.
  - Counters saturate at all-ones and do not wrap.
  - The first error since reset or clear_error loads first_err_type and first_err_data. If both errors occur in that cycle, type=2'b11 and data comes from the timestamp data.
  - Later errors do not overwrite the first-error capture.
  - Error data is sampled in the same cycle as its flag, since the core registers both together.
- clear_error zeroes the sticky flags, first_err_type, first_err_data and both error counters.
  - match_count is not affected by clear_error.
  - If an error arrives in the same cycle as clear_error, the new error wins: the flag is set, the count becomes 1 and the capture loads.
- match_count increments on each core_counter_matched cycle and saturates.
- All comparisons are unsigned 64-bit.

Decomposition:
- Package rto_ctrl_pkg: the state enum (3-bit codes above), the first-error-type bit positions, and a localparam for the default timestamp width (64).
- One sub-module, sat_counter (parameter W; ports inc, clr, count), instantiated three times for ts_err_count, ovf_err_count and match_count.

Test Plan:
- start_cmd with start_time=1000 while counter=990 -> ARMED; auto_start rises on the cycle after the counter reaches 1000; match_count=0 at arm.
- RUNNING, core_timestamp_error pulse with data 0xDEAD..01 -> HALTED, auto_start=0 one cycle later, sticky_ts_err=1, first_err_type=01, ts_err_count=1; start_cmd ignored; clear_error -> IDLE with all error state cleared.
- Both errors in one cycle with ts data A and ovf data B -> first_err_type=11, first_err_data=A; a later ovf error with data C leaves the capture unchanged and gives ovf_err_count=2.
- flush_cmd and stop_cmd together in RUNNING -> FLUSHING; flush high for exactly 4 cycles; auto_start=0 throughout; then IDLE with busy=0.
- AUTO_STOP=1: core_empty high for 15 cycles, low for 1, then high for 16 -> the run ends only after the second window, on the 16th cycle.
- ERR_CNT_W=4 with 20 timestamp error cycles and HALT_ON_ERROR=0 -> ts_err_count=15 and the FSM stays in RUNNING; asserting reset mid-run -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/rto_core_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// rto_ctrl_pkg : shared types for the RTO core run-control sequencer
// Rev 1.0
// ============================================================================
package rto_ctrl_pkg;

    localparam int TS_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_FLUSHING = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

    // Bit positions inside first_err_type
    localparam int FE_TS_BIT  = 0;
    localparam int FE_OVF_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/rto_core_sequencer_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating up-counter; clr with inc in one cycle yields 1
// Rev 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? {{(W-1){1'b0}}, 1'b1} : '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rto_core_sequencer.sv
`default_nettype none
// ============================================================================
// rto_core_sequencer : run-control FSM and error bookkeeping for one RTO core
// Rev 1.0
// ============================================================================
module rto_core_sequencer
    import rto_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 4,
    parameter int DRAIN_IDLE    = 16,
    parameter bit HALT_ON_ERROR = 1'b1,
    parameter bit AUTO_STOP     = 1'b1,
    parameter int CNT_W         = 32,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TS_W-1:0]      counter,
    input  logic                 start_cmd,
    input  logic [TS_W-1:0]      start_time,
    input  logic                 stop_cmd,
    input  logic                 flush_cmd,
    input  logic                 clear_error,
    input  logic                 core_timestamp_error,
    input  logic                 core_overflow_error,
    input  logic [127:0]         core_timestamp_error_data,
    input  logic [127:0]         core_overflow_error_data,
    input  logic                 core_empty,
    input  logic                 core_counter_matched,
    output logic                 auto_start,
    output logic                 flush,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 sticky_ts_err,
    output logic                 sticky_ovf_err,
    output logic [1:0]           first_err_type,
    output logic [127:0]         first_err_data,
    output logic [ERR_CNT_W-1:0] ts_err_count,
    output logic [ERR_CNT_W-1:0] ovf_err_count,
    output logic [CNT_W-1:0]     match_count
);

    localparam int DW = $clog2(DRAIN_IDLE + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    state_t          r_state;
    state_t          w_next;
    logic [TS_W-1:0] r_start_time;
    logic [DW-1:0]   r_drain;
    logic [FW-1:0]   r_fcnt;
    logic            r_auto_start;
    logic            r_flush;
    logic            r_busy;
    logic            r_sticky_ts;
    logic            r_sticky_ovf;
    logic [1:0]      r_first_type;
    logic [127:0]    r_first_data;
    logic            w_any_err;
    logic            w_arm;
    logic            w_cap;
    logic [1:0]      w_new_type;

    assign w_any_err = core_timestamp_error | core_overflow_error;
    assign w_arm     = (r_state == ST_IDLE) && start_cmd && !flush_cmd && !stop_cmd;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (flush_cmd)      w_next = ST_FLUSHING;
                else if (w_arm)     w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (flush_cmd)                    w_next = ST_FLUSHING;
                else if (stop_cmd)                w_next = ST_IDLE;
                else if (counter >= r_start_time) w_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (flush_cmd)                        w_next = ST_FLUSHING;
                else if (stop_cmd)                    w_next = ST_IDLE;
                else if (HALT_ON_ERROR && w_any_err)  w_next = ST_HALTED;
                else if (AUTO_STOP && core_empty &&
                         (r_drain == DW'(DRAIN_IDLE - 1)))
                    w_next = ST_IDLE;
            end
            ST_FLUSHING: begin
                if (r_fcnt == FW'(FLUSH_CYCLES - 1)) w_next = ST_IDLE;
            end
            ST_HALTED: begin
                if (flush_cmd)        w_next = ST_FLUSHING;
                else if (clear_error) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_start_time <= '0;
            r_drain      <= '0;
            r_fcnt       <= '0;
            r_auto_start <= 1'b0;
            r_flush      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_auto_start <= (w_next == ST_RUNNING);
            r_flush      <= (w_next == ST_FLUSHING);
            r_busy       <= (w_next != ST_IDLE);
            if (w_arm) r_start_time <= start_time;
            r_drain <= (r_state == ST_RUNNING && w_next == ST_RUNNING && core_empty)
                       ? r_drain + 1'b1 : '0;
            r_fcnt  <= (r_state == ST_FLUSHING && w_next == ST_FLUSHING)
                       ? r_fcnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_new_type             = 2'b00;
        w_new_type[FE_TS_BIT]  = core_timestamp_error;
        w_new_type[FE_OVF_BIT] = core_overflow_error;
    end

    // A zero type means nothing captured yet; clear_error re-opens the capture in the same cycle
    assign w_cap = w_any_err && (clear_error || (r_first_type == 2'b00));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky_ts  <= 1'b0;
            r_sticky_ovf <= 1'b0;
            r_first_type <= 2'b00;
            r_first_data <= '0;
        end else begin
            if (clear_error) begin
                r_sticky_ts  <= core_timestamp_error;
                r_sticky_ovf <= core_overflow_error;
            end else begin
                r_sticky_ts  <= r_sticky_ts  | core_timestamp_error;
                r_sticky_ovf <= r_sticky_ovf | core_overflow_error;
            end
            if (w_cap) begin
                r_first_type <= w_new_type;
                r_first_data <= core_timestamp_error ? core_timestamp_error_data
                                                     : core_overflow_error_data;
            end else if (clear_error) begin
                r_first_type <= 2'b00;
                r_first_data <= '0;
            end
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_ts_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (core_timestamp_error),
        .clr   (clear_error),
        .count (ts_err_count)
    );

    sat_counter #(.W(ERR_CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (core_overflow_error),
        .clr   (clear_error),
        .count (ovf_err_count)
    );

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (core_counter_matched),
        .clr   (w_arm),
        .count (match_count)
    );

    assign auto_start     = r_auto_start;
    assign flush          = r_flush;
    assign state          = r_state;
    assign busy           = r_busy;
    assign sticky_ts_err  = r_sticky_ts;
    assign sticky_ovf_err = r_sticky_ovf;
    assign first_err_type = r_first_type;
    assign first_err_data = r_first_data;

endmodule
`default_nettype wire

// File: tb/tb_rto_core_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rto_core_sequencer : directed self-checking bench for rto_core_sequencer
// Rev 1.0
// ============================================================================
module tb_rto_core_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  counter;
    logic         start_cmd, stop_cmd, flush_cmd, clear_error;
    logic [63:0]  start_time;
    logic         ts_err, ovf_err, core_empty, matched;
    logic [127:0] ts_data, ovf_data;

    logic         a_auto, a_flush, a_busy, a_sts, a_sovf;
    logic [2:0]   a_state;
    logic [1:0]   a_ftype;
    logic [127:0] a_fdata;
    logic [15:0]  a_tscnt, a_ovfcnt;
    logic [31:0]  a_match;

    logic         b_auto, b_flush, b_busy, b_sts, b_sovf;
    logic [2:0]   b_state;
    logic [1:0]   b_ftype;
    logic [127:0] b_fdata;
    logic [3:0]   b_tscnt, b_ovfcnt;
    logic [31:0]  b_match;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DATA_A = 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] DATA_B = 128'hBBBB_0000_0000_0000_0000_0000_0000_0002;
    localparam logic [127:0] DATA_C = 128'hCCCC_0000_0000_0000_0000_0000_0000_0003;

    always #5 clk = ~clk;

    rto_core_sequencer u_dut (
        .clk(clk), .reset(reset), .counter(counter),
        .start_cmd(start_cmd), .start_time(start_time), .stop_cmd(stop_cmd),
        .flush_cmd(flush_cmd), .clear_error(clear_error),
        .core_timestamp_error(ts_err), .core_overflow_error(ovf_err),
        .core_timestamp_error_data(ts_data), .core_overflow_error_data(ovf_data),
        .core_empty(core_empty), .core_counter_matched(matched),
        .auto_start(a_auto), .flush(a_flush), .state(a_state), .busy(a_busy),
        .sticky_ts_err(a_sts), .sticky_ovf_err(a_sovf),
        .first_err_type(a_ftype), .first_err_data(a_fdata),
        .ts_err_count(a_tscnt), .ovf_err_count(a_ovfcnt), .match_count(a_match)
    );

    rto_core_sequencer #(.ERR_CNT_W(4), .HALT_ON_ERROR(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .counter(counter),
        .start_cmd(start_cmd), .start_time(start_time), .stop_cmd(stop_cmd),
        .flush_cmd(flush_cmd), .clear_error(clear_error),
        .core_timestamp_error(ts_err), .core_overflow_error(ovf_err),
        .core_timestamp_error_data(ts_data), .core_overflow_error_data(ovf_data),
        .core_empty(core_empty), .core_counter_matched(matched),
        .auto_start(b_auto), .flush(b_flush), .state(b_state), .busy(b_busy),
        .sticky_ts_err(b_sts), .sticky_ovf_err(b_sovf),
        .first_err_type(b_ftype), .first_err_data(b_fdata),
        .ts_err_count(b_tscnt), .ovf_err_count(b_ovfcnt), .match_count(b_match)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; counter = '0; start_time = '0;
        start_cmd = 0; stop_cmd = 0; flush_cmd = 0; clear_error = 0;
        ts_err = 0; ovf_err = 0; core_empty = 0; matched = 0;
        ts_data = '0; ovf_data = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", 128'(a_state), 128'd0);
        chk("rst_auto", 128'(a_auto), 128'd0);
        chk("rst_flush", 128'(a_flush), 128'd0);
        chk("rst_busy", 128'(a_busy), 128'd0);
        chk("rst_fdata", a_fdata, 128'd0);

        // Arm in the future
        counter = 64'd990; start_time = 64'd1000; start_cmd = 1;
        tick();
        start_cmd = 0;
        chk("arm_state", 128'(a_state), 128'd1);
        chk("arm_busy", 128'(a_busy), 128'd1);
        chk("arm_match", 128'(a_match), 128'd0);
        counter = 64'd999;
        tick();
        chk("arm_999_auto", 128'(a_auto), 128'd0);
        chk("arm_999_state", 128'(a_state), 128'd1);
        counter = 64'd1000;
        tick();
        chk("run_auto", 128'(a_auto), 128'd1);
        chk("run_state", 128'(a_state), 128'd2);
        matched = 1;
        tick(); tick(); tick();
        matched = 0;
        chk("match_cnt", 128'(a_match), 128'd3);

        // Timestamp error halts
        ts_err = 1; ts_data = DATA_A;
        tick();
        ts_err = 0;
        chk("halt_state", 128'(a_state), 128'd4);
        chk("halt_auto", 128'(a_auto), 128'd0);
        chk("halt_sticky", 128'(a_sts), 128'd1);
        chk("halt_ftype", 128'(a_ftype), 128'd1);
        chk("halt_fdata", a_fdata, DATA_A);
        chk("halt_tscnt", 128'(a_tscnt), 128'd1);
        start_cmd = 1;
        tick();
        start_cmd = 0;
        chk("halt_ign_start", 128'(a_state), 128'd4);
        clear_error = 1;
        tick();
        clear_error = 0;
        chk("clr_state", 128'(a_state), 128'd0);
        chk("clr_sticky", 128'(a_sts), 128'd0);
        chk("clr_ftype", 128'(a_ftype), 128'd0);
        chk("clr_fdata", a_fdata, 128'd0);
        chk("clr_tscnt", 128'(a_tscnt), 128'd0);
        chk("clr_keep_match", 128'(a_match), 128'd3);

        // Simultaneous errors, then a later overflow
        ts_err = 1; ovf_err = 1; ts_data = DATA_A; ovf_data = DATA_B;
        tick();
        ts_err = 0;
        chk("both_ftype", 128'(a_ftype), 128'd3);
        chk("both_fdata", a_fdata, DATA_A);
        chk("both_sovf", 128'(a_sovf), 128'd1);
        ovf_data = DATA_C;
        tick();
        ovf_err = 0;
        chk("later_fdata", a_fdata, DATA_A);
        chk("later_ftype", 128'(a_ftype), 128'd3);
        chk("later_ovfcnt", 128'(a_ovfcnt), 128'd2);
        chk("later_tscnt", 128'(a_tscnt), 128'd1);
        clear_error = 1;
        tick();
        clear_error = 0;

        // Flush beats stop in RUNNING
        counter = 64'd2000; start_time = 64'd0; start_cmd = 1;
        tick();
        start_cmd = 0;
        tick();
        chk("f_run_state", 128'(a_state), 128'd2);
        flush_cmd = 1; stop_cmd = 1;
        tick();
        flush_cmd = 0; stop_cmd = 0;
        chk("f_state", 128'(a_state), 128'd3);
        chk("f_flush1", 128'(a_flush), 128'd1);
        chk("f_auto1", 128'(a_auto), 128'd0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("f_flush%0d", i), 128'(a_flush), 128'd1);
            chk($sformatf("f_auto%0d", i), 128'(a_auto), 128'd0);
        end
        tick();
        chk("f_end_flush", 128'(a_flush), 128'd0);
        chk("f_end_state", 128'(a_state), 128'd0);
        chk("f_end_busy", 128'(a_busy), 128'd0);

        // Drain window restarts on a non-empty cycle
        start_cmd = 1;
        tick();
        start_cmd = 0;
        tick();
        chk("d_run", 128'(a_state), 128'd2);
        core_empty = 1;
        for (int i = 0; i < 15; i++) tick();
        chk("d_after15", 128'(a_state), 128'd2);
        core_empty = 0;
        tick();
        core_empty = 1;
        for (int i = 0; i < 15; i++) tick();
        chk("d_second15", 128'(a_state), 128'd2);
        tick();
        core_empty = 0;
        chk("d_end_state", 128'(a_state), 128'd0);
        chk("d_end_auto", 128'(a_auto), 128'd0);

        // Saturation without halting, then reset mid-run
        reset = 1;
        tick();
        reset = 0;
        start_cmd = 1;
        tick();
        start_cmd = 0;
        tick();
        chk("s_run_b", 128'(b_state), 128'd2);
        ts_err = 1; ts_data = DATA_B;
        for (int i = 0; i < 20; i++) tick();
        ts_err = 0;
        chk("s_b_cnt", 128'(b_tscnt), 128'd15);
        chk("s_b_state", 128'(b_state), 128'd2);
        chk("s_b_auto", 128'(b_auto), 128'd1);
        chk("s_a_cnt", 128'(a_tscnt), 128'd20);
        chk("s_a_state", 128'(a_state), 128'd4);
        reset = 1;
        tick();
        reset = 0;
        chk("r_b_state", 128'(b_state), 128'd0);
        chk("r_b_auto", 128'(b_auto), 128'd0);
        chk("r_b_flush", 128'(b_flush), 128'd0);
        chk("r_b_busy", 128'(b_busy), 128'd0);
        chk("r_b_sticky", 128'({b_sts, b_sovf}), 128'd0);
        chk("r_b_ftype", 128'(b_ftype), 128'd0);
        chk("r_b_fdata", b_fdata, 128'd0);
        chk("r_b_cnts", 128'({b_tscnt, b_ovfcnt}), 128'd0);
        chk("r_b_match", 128'(b_match), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
